// File: rtl/elastic_fifo_pkg.sv
// Shared constants and helpers for the modal elastic FIFO.
package elastic_fifo_pkg;

  localparam int MODE_TRANSPARENT   = 0;
  localparam int MODE_OPAQUE        = 1;
  localparam int MODE_OPAQUE_RBREAK = 2;

  // Ceiling log2 with a floor of 1, so single-slot storage still gets a 1-bit pointer.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_ring_store.sv
// Circular storage: memory array, head/tail pointers with arbitrary-depth wrap,
// and a registered occupancy count. Push/pop are already qualified by the caller.
module fifo_ring_store
  import elastic_fifo_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int DATA_TYPE = 32,
  localparam int PW = clog2_min1(NUM_SLOTS),
  localparam int CW = clog2_min1(NUM_SLOTS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_TYPE-1:0] wr_data,
  output logic [DATA_TYPE-1:0] rd_data,
  output logic [CW-1:0]        count
);

  logic [DATA_TYPE-1:0] mem [NUM_SLOTS];
  logic [PW-1:0]        head_reg;
  logic [PW-1:0]        tail_reg;
  logic [CW-1:0]        count_reg;

  // Next pointer value; the last slot wraps to zero regardless of power-of-two depth.
  function automatic logic [PW-1:0] advance(input logic [PW-1:0] p);
    if (p == PW'(NUM_SLOTS - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Payload write at the tail slot; handshakes during reset are ignored.
  always_ff @(posedge clk) begin
    if (rst && push) mem[tail_reg] <= wr_data;
  end

  // Pointer and occupancy bookkeeping, flushed by the active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= advance(tail_reg);
      if (pop)  head_reg <= advance(head_reg);
      if (push && !pop)      count_reg <= count_reg + CW'(1);
      else if (pop && !push) count_reg <= count_reg - CW'(1);
    end
  end

  assign rd_data = mem[head_reg];
  assign count   = count_reg;

endmodule

// File: rtl/elastic_fifo_modal.sv
// Elastic FIFO with compile-time buffering mode: transparent bypass, opaque,
// or opaque with registered ready. Storage lives in fifo_ring_store; this level
// only shapes the handshake around it.
module elastic_fifo_modal
  import elastic_fifo_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int DATA_TYPE = 32,
  parameter int MODE      = 1,
  localparam int CW = clog2_min1(NUM_SLOTS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_TYPE-1:0] ins,
  input  logic                 ins_valid,
  output logic                 ins_ready,
  output logic [DATA_TYPE-1:0] outs,
  output logic                 outs_valid,
  input  logic                 outs_ready,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic                 empty
);

  logic                 push;
  logic                 pop;
  logic                 store_push;
  logic                 store_pop;
  logic [DATA_TYPE-1:0] rd_data;

  // Status is decoded purely from the registered count.
  assign full  = (count == CW'(NUM_SLOTS));
  assign empty = (count == '0);

  assign push = ins_valid & ins_ready;
  assign pop  = outs_valid & outs_ready;

  generate
    if (MODE == MODE_TRANSPARENT) begin : g_transparent
      logic bypass;
      // When empty, the input flows straight through; a simultaneous push and
      // pop then never touches storage.
      assign bypass     = empty & push & pop;
      assign outs       = empty ? ins : rd_data;
      assign outs_valid = ins_valid | ~empty;
      assign ins_ready  = ~full | outs_ready;
      assign store_push = push & ~bypass;
      assign store_pop  = pop & ~bypass;
    end else if (MODE == MODE_OPAQUE) begin : g_opaque
      // Output always comes from storage; a full buffer may still accept when
      // the head is leaving in the same cycle.
      assign outs       = rd_data;
      assign outs_valid = ~empty;
      assign ins_ready  = ~full | outs_ready;
      assign store_push = push;
      assign store_pop  = pop;
    end else begin : g_opaque_rbreak
      // Ready depends only on registered occupancy, cutting the backward path.
      assign outs       = rd_data;
      assign outs_valid = ~empty;
      assign ins_ready  = ~full;
      assign store_push = push;
      assign store_pop  = pop;
    end
  endgenerate

  fifo_ring_store #(
    .NUM_SLOTS (NUM_SLOTS),
    .DATA_TYPE (DATA_TYPE)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .push    (store_push),
    .pop     (store_pop),
    .wr_data (ins),
    .rd_data (rd_data),
    .count   (count)
  );

endmodule
